// File: rtl/dem_sched_ctrl_if.sv
// Handshake bundle between the sample source, config master, the scheduler and
// the DEM switching blocks.
interface dem_sched_ctrl_if #(
  parameter int INPUT_WIDTH  = 16,
  parameter int SWITCH_WIDTH = 5
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [1:0]              cfg_mode;
  logic [15:0]             cfg_seed;
  logic                    in_valid;
  logic                    in_ready;
  logic [INPUT_WIDTH-1:0]  x_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [SWITCH_WIDTH-1:0] out_level;
  logic [SWITCH_WIDTH-1:0] s_out;
  logic                    out_sat;

  modport slave (
    input  cfg_valid, cfg_mode, cfg_seed, in_valid, x_in, out_ready,
    output cfg_ready, in_ready, out_valid, out_level, s_out, out_sat
  );

  modport master (
    output cfg_valid, cfg_mode, cfg_seed, in_valid, x_in, out_ready,
    input  cfg_ready, in_ready, out_valid, out_level, s_out, out_sat
  );
endinterface

// File: rtl/dem_sched_ctrl.sv
// DEM-DAC sample scheduler: quantises samples to unit-element levels and picks
// the element select from a PN, rotation or static schedule.
module dem_sched_ctrl #(
  parameter int          INPUT_WIDTH  = 16,
  parameter int          SWITCH_WIDTH = 5,
  parameter int          SCALE_SHIFT  = 4,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  dem_sched_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, LOAD} state_e;

  localparam logic [1:0] MODE_PN     = 2'b00;
  localparam logic [1:0] MODE_ROT    = 2'b01;
  localparam logic [1:0] MODE_STATIC = 2'b10;
  localparam int         LVL_W       = INPUT_WIDTH + 1;
  localparam logic signed [LVL_W-1:0] LVL_OFS = LVL_W'(2**(SWITCH_WIDTH-1));
  localparam logic signed [LVL_W-1:0] LVL_MAX = LVL_W'(2**SWITCH_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [SWITCH_WIDTH-1:0] ptr_q, ptr_d;
  logic                    out_valid_q, out_valid_d;
  logic [SWITCH_WIDTH-1:0] out_level_q, out_level_d;
  logic [SWITCH_WIDTH-1:0] s_out_q, s_out_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [LVL_W-1:0] x_ext, t;
  logic [SWITCH_WIDTH-1:0] lvl;
  logic                    sat;
  logic                    in_ready, cfg_ready, in_hs;
  logic [15:0]             lfsr_step, seed_ld;

  assign cfg_ready = (state_q == IDLE) || (state_q == LOAD);
  // A pending config blocks new samples so the drain sees a quiescent pipe.
  assign in_ready  = (state_q == RUN) && !bus.cfg_valid && (!out_valid_q || bus.out_ready);
  assign in_hs     = bus.in_valid && in_ready;
  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // An all-zero seed would lock the LFSR.
  assign seed_ld   = (bus.cfg_seed == 16'd0) ? DEFAULT_SEED : bus.cfg_seed;

  always_comb begin
    x_ext = {bus.x_in[INPUT_WIDTH-1], bus.x_in};
    t     = (x_ext >>> SCALE_SHIFT) + LVL_OFS;
    lvl   = t[SWITCH_WIDTH-1:0];
    sat   = 1'b0;
    if (t[LVL_W-1]) begin
      lvl = '0;
      sat = 1'b1;
    end else if (t > LVL_MAX) begin
      lvl = '1;
      sat = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lfsr_d      = lfsr_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_level_d = out_level_q;
    s_out_d     = s_out_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      IDLE: if (bus.cfg_valid) begin
        mode_d  = bus.cfg_mode;
        lfsr_d  = seed_ld;
        state_d = RUN;
      end
      RUN:   if (bus.cfg_valid) state_d = DRAIN;
      DRAIN: if (!out_valid_q || bus.out_ready) state_d = LOAD;
      LOAD: begin
        mode_d  = bus.cfg_mode;
        lfsr_d  = seed_ld;
        ptr_d   = '0;
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // Handshakes only occur in RUN, so schedule updates never collide with loads.
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_level_d = lvl;
      out_sat_d   = sat;
      case (mode_q)
        MODE_PN: begin
          s_out_d = lfsr_q[SWITCH_WIDTH-1:0];
          lfsr_d  = lfsr_step;
        end
        MODE_ROT: begin
          s_out_d = ptr_q;
          ptr_d   = ptr_q + lvl;
        end
        default: s_out_d = '0;
      endcase
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_STATIC;
      lfsr_q      <= DEFAULT_SEED;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_level_q <= '0;
      s_out_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lfsr_q      <= lfsr_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_level_q <= out_level_d;
      s_out_q     <= s_out_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_level = out_level_q;
  assign bus.s_out     = s_out_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_dem_sched_ctrl.sv
// Bench for dem_sched_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of the schedules.
module tb_dem_sched_ctrl;
  localparam int IW = 16;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dem_sched_ctrl_if #(.INPUT_WIDTH(IW), .SWITCH_WIDTH(SW)) bus();

  dem_sched_ctrl #(
    .INPUT_WIDTH(IW), .SWITCH_WIDTH(SW), .SCALE_SHIFT(4), .DEFAULT_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0]  m_mode;
  logic [15:0] m_lfsr;
  int          m_ptr;
  logic        m_vld;
  logic [4:0]  m_lvl, m_sv;
  logic        m_sat;

  function automatic int floor_div16(input int x);
    return (x >= 0) ? x / 16 : -((-x + 15) / 16);
  endfunction

  task automatic model_reset();
    m_mode = 2'b10; m_lfsr = 16'hACE1; m_ptr = 0; m_vld = 1'b0;
  endtask

  task automatic model_sample(input int x, output logic [4:0] lvl, output logic [4:0] sv,
                              output logic sat);
    int t;
    t   = floor_div16(x) + 16;
    sat = (t < 0) || (t > 31);
    lvl = (t < 0) ? 5'd0 : (t > 31) ? 5'd31 : 5'(t);
    case (m_mode)
      2'b00: begin
        sv     = m_lfsr[4:0];
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
      end
      2'b01: begin
        sv    = 5'(m_ptr);
        m_ptr = (m_ptr + int'(lvl)) % 32;
      end
      default: sv = 5'd0;
    endcase
  endtask

  task automatic cfg(input logic [1:0] mode, input logic [15:0] seed);
    int n = 0;
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_mode = mode; bus.cfg_seed = seed; bus.out_ready = 1'b1;
    #1;
    while (!bus.cfg_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.cfg_ready) begin
      checks++; errors++;
      $display("FAIL cfg_timeout: cfg_ready=%b want 1 within 20 cycles", bus.cfg_ready);
    end
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    m_mode = mode; m_lfsr = (seed == 16'd0) ? 16'hACE1 : seed; m_ptr = 0; m_vld = 1'b0;
  endtask

  task automatic send(input int x, output logic [4:0] lvl, output logic [4:0] sv,
                      output logic sat);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.x_in = 16'(x); bus.out_ready = 1'b1;
    #1;
    while (!bus.in_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b want 1 within 20 cycles", bus.in_ready);
    end
    @(posedge clk); #1;
    lvl = bus.out_level; sv = bus.s_out; sat = bus.out_sat;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks += 6;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_level !== 5'd0) begin errors++; $display("FAIL rst_out_level: got %0d want 0", bus.out_level); end
    if (bus.s_out !== 5'd0)     begin errors++; $display("FAIL rst_s_out: got %0d want 0", bus.s_out); end
    if (bus.out_sat !== 1'b0)   begin errors++; $display("FAIL rst_out_sat: got %b want 0", bus.out_sat); end
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b want 1", bus.cfg_ready); end
    if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
  endtask

  task automatic test_pn();
    logic [4:0] l, s, el, es; logic t, et;
    cfg(2'b00, 16'hACE1);
    send(50, l, s, t); model_sample(50, el, es, et);
    checks += 3;
    if (l !== 5'd19)   begin errors++; $display("FAIL pn_level0: got %0d want 19", l); end
    if (s !== 5'h01)   begin errors++; $display("FAIL pn_s_out0: got %0h want 01", s); end
    if (t !== 1'b0)    begin errors++; $display("FAIL pn_sat0: got %b want 0", t); end
    send(50, l, s, t); model_sample(50, el, es, et);
    checks += 2;
    if (l !== 5'd19)   begin errors++; $display("FAIL pn_level1: got %0d want 19", l); end
    if (s !== 5'h03)   begin errors++; $display("FAIL pn_s_out1: got %0h want 03", s); end
  endtask

  task automatic test_rotate();
    int xs[3]   = '{50, 50, 0};
    int lvls[3] = '{19, 19, 16};
    int sels[3] = '{0, 19, 6};
    logic [4:0] l, s, el, es; logic t, et;
    cfg(2'b01, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      send(xs[i], l, s, t); model_sample(xs[i], el, es, et);
      checks += 2;
      if (l !== 5'(lvls[i])) begin errors++; $display("FAIL rot_level%0d: got %0d want %0d", i, l, lvls[i]); end
      if (s !== 5'(sels[i])) begin errors++; $display("FAIL rot_s_out%0d: got %0d want %0d", i, s, sels[i]); end
    end
  endtask

  task automatic test_boundaries();
    int xs[4]   = '{1000, -50, -32768, 0};
    int lvls[4] = '{31, 12, 0, 16};
    logic sats[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] l, s, el, es; logic t, et;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], l, s, t); model_sample(xs[i], el, es, et);
      checks += 3;
      if (l !== 5'(lvls[i])) begin errors++; $display("FAIL bnd_level x=%0d: got %0d want %0d", xs[i], l, lvls[i]); end
      if (t !== sats[i])     begin errors++; $display("FAIL bnd_sat x=%0d: got %b want %b", xs[i], t, sats[i]); end
      if (s !== es)          begin errors++; $display("FAIL bnd_s_out x=%0d: got %0d want %0d", xs[i], s, es); end
    end
  endtask

  task automatic test_backpressure();
    int x;
    cfg(2'b00, 16'h1234);
    @(negedge clk);
    x = int'($urandom_range(0, 1023)) - 512;
    bus.in_valid = 1'b1; bus.x_in = 16'(x); bus.out_ready = 1'b0;
    model_sample(x, m_lvl, m_sv, m_sat);
    #1; checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.x_in = 16'($urandom);
      #1; checks += 3;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %b want 1", i, bus.out_valid); end
      if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL bp_hold_ready c%0d: got %b want 0", i, bus.in_ready); end
      if ({bus.out_level, bus.s_out, bus.out_sat} !== {m_lvl, m_sv, m_sat}) begin
        errors++;
        $display("FAIL bp_hold_data c%0d: got %0d/%0h/%b want %0d/%0h/%b", i,
                 bus.out_level, bus.s_out, bus.out_sat, m_lvl, m_sv, m_sat);
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      x = int'($urandom_range(0, 65535)) - 32768;
      bus.out_ready = 1'b1; bus.x_in = 16'(x);
      model_sample(x, m_lvl, m_sv, m_sat);
      #1; checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_tput_ready s%0d: got %b want 1", i, bus.in_ready); end
      @(posedge clk); #1; checks += 2;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_tput_valid s%0d: got %b want 1", i, bus.out_valid); end
      if ({bus.out_level, bus.s_out, bus.out_sat} !== {m_lvl, m_sv, m_sat}) begin
        errors++;
        $display("FAIL bp_tput_data s%0d: got %0d/%0h/%b want %0d/%0h/%b", i,
                 bus.out_level, bus.s_out, bus.out_sat, m_lvl, m_sv, m_sat);
      end
    end
    @(negedge clk); bus.in_valid = 1'b0;
  endtask

  task automatic test_reconfig();
    logic [4:0] el, es; logic et;
    cfg(2'b00, 16'h5A5A);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.x_in = 16'd200; bus.out_ready = 1'b0;
    model_sample(200, m_lvl, m_sv, m_sat);
    @(posedge clk); #1;
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_mode = 2'b00; bus.cfg_seed = 16'd0; bus.x_in = 16'd50;
    #1; checks += 2;
    if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rc_run_in_ready: got %b want 0", bus.in_ready); end
    if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL rc_run_cfg_ready: got %b want 0", bus.cfg_ready); end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1; checks += 4;
      if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL rc_drain_cfg_ready c%0d: got %b want 0", i, bus.cfg_ready); end
      if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rc_drain_in_ready c%0d: got %b want 0", i, bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rc_drain_valid c%0d: got %b want 1", i, bus.out_valid); end
      if ({bus.out_level, bus.s_out} !== {m_lvl, m_sv}) begin
        errors++; $display("FAIL rc_drain_data c%0d: got %0d/%0h want %0d/%0h", i, bus.out_level, bus.s_out, m_lvl, m_sv);
      end
    end
    @(negedge clk); bus.out_ready = 1'b1;
    #1; checks++;
    if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL rc_pop_cfg_ready: got %b want 0", bus.cfg_ready); end
    @(posedge clk); #1; checks += 3;
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rc_load_cfg_ready: got %b want 1", bus.cfg_ready); end
    if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL rc_load_in_ready: got %b want 0", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rc_load_valid: got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    m_mode = 2'b00; m_lfsr = 16'hACE1; m_ptr = 0; m_vld = 1'b0;
    #1; checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rc_resume_ready: got %b want 1", bus.in_ready); end
    model_sample(50, el, es, et);
    @(posedge clk); #1; checks += 3;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rc_next_valid: got %b want 1", bus.out_valid); end
    if (bus.s_out !== 5'h01)    begin errors++; $display("FAIL rc_next_s_out: got %0h want 01", bus.s_out); end
    if (bus.out_level !== 5'd19) begin errors++; $display("FAIL rc_next_level: got %0d want 19", bus.out_level); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_cfg_wins();
    @(negedge clk);
    bus.cfg_valid = 1'b1; bus.cfg_mode = 2'b01; bus.cfg_seed = 16'h0001;
    bus.in_valid = 1'b1; bus.x_in = 16'd50; bus.out_ready = 1'b1;
    #1; checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL cw_in_ready: got %b want 0", bus.in_ready); end
    @(posedge clk); #1; checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cw_no_take: out_valid=%b want 0", bus.out_valid); end
    bus.in_valid = 1'b0;
    cfg(2'b01, 16'h0001);
  endtask

  task automatic test_random(input logic [1:0] mode);
    int x; logic exp_rdy;
    cfg(mode, 16'($urandom));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      x = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 65535)) - 32768
                                       : int'($urandom_range(0, 1023)) - 512;
      bus.x_in = 16'(x);
      #1;
      exp_rdy = !m_vld || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_m%0d_ready c%0d: got %b want %b", mode, i, bus.in_ready, exp_rdy); end
      if (bus.in_valid && exp_rdy) begin
        model_sample(x, m_lvl, m_sv, m_sat); m_vld = 1'b1;
      end else if (bus.out_ready) begin
        m_vld = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== m_vld) begin errors++; $display("FAIL rnd_m%0d_valid c%0d: got %b want %b", mode, i, bus.out_valid, m_vld); end
      if (m_vld) begin
        checks++;
        if ({bus.out_level, bus.s_out, bus.out_sat} !== {m_lvl, m_sv, m_sat}) begin
          errors++;
          $display("FAIL rnd_m%0d_data c%0d: got %0d/%0h/%b want %0d/%0h/%b", mode, i,
                   bus.out_level, bus.s_out, bus.out_sat, m_lvl, m_sv, m_sat);
        end
      end
    end
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    cfg(2'b00, 16'h00FF);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.x_in = 16'd100; bus.out_ready = 1'b0;
    @(posedge clk); #1; checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rm_pending: out_valid=%b want 1", bus.out_valid); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    test_reset();
    @(negedge clk); reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    model_reset();
    #1; checks++;
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL rm_idle_cfg_ready: got %b want 1", bus.cfg_ready); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_mode = 2'b00; bus.cfg_seed = 16'd0;
    bus.in_valid = 1'b0; bus.x_in = '0; bus.out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    test_reset();
    test_pn();
    test_rotate();
    test_boundaries();
    test_backpressure();
    test_reconfig();
    test_cfg_wins();
    test_random(2'b00);
    test_random(2'b01);
    test_random(2'b10);
    test_random(2'b11);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/dem_sched_ctrl.md
# dem_sched_ctrl

Sample scheduler and element-selection controller for the DEM-DAC datapath. It sits between the sample source and the switching blocks. It accepts signed 16-bit samples over a valid/ready handshake, quantises each one to a unit-element level, and issues the per-sample switching select. The select comes from one of three configurable schedules: PN (LFSR), rotation (data-weighted averaging) or static. Configuration (mode, seed) can be changed at run time through a drain-then-load sequence that never corrupts an in-flight sample.

## Interface
- INPUT_WIDTH, 16: sample width, signed two's complement.
- SWITCH_WIDTH, 5: level/select width; 2^SWITCH_WIDTH unit elements.
- SCALE_SHIFT, 4: arithmetic right shift applied before level offset.
- DEFAULT_SEED, 16'hACE1: LFSR seed after reset and when a zero seed is loaded.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; one clock; no other clock domains.
- cfg_valid  input  1  config request; held until accepted.
- cfg_ready  output  1  config accept; high only in IDLE and LOAD.
- cfg_mode  input  2  00 PN, 01 rotate, 10 static, 11 treated as static.
- cfg_seed  input  16  LFSR seed.
- in_valid  input  1  sample valid.
- in_ready  output  1  sample accept.
- x_in  input  INPUT_WIDTH  signed sample.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer accept.
- out_level  output  SWITCH_WIDTH  quantised level.
- s_out  output  SWITCH_WIDTH  switching select for the switching blocks.
- out_sat  output  1  level was clamped.

## Operation
- States: IDLE, RUN, DRAIN, LOAD. Reset enters IDLE.
- IDLE: cfg_ready=1, in_ready=0. When cfg_valid is high, latch mode and seed, then go to RUN.
- RUN: in_ready = !cfg_valid && (!out_valid || out_ready). When cfg_valid=1, go to DRAIN; no sample is accepted that cycle.
- DRAIN: in_ready=0. When out_valid=0 or (out_valid && out_ready), go to LOAD.
- LOAD: cfg_ready=1. Latch mode and seed, reset the rotation pointer to 0, then go to RUN. cfg_valid is guaranteed high here by protocol (held until accepted).
- Seed load: a cfg_seed of 0 loads DEFAULT_SEED to avoid LFSR lockup.
- Quantiser: t = (x_in >>> SCALE_SHIFT) + 2^(SWITCH_WIDTH-1), computed signed at INPUT_WIDTH+1 bits.
  - out_level = clamp(t, 0, 2^SWITCH_WIDTH-1).
  - out_sat=1 if clamping occurred.
- PN mode: s_out = lfsr[SWITCH_WIDTH-1:0] (current value), then the LFSR advances one step per accepted sample.
  - Step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Rotate mode: s_out = ptr, then ptr <= (ptr + out_level) mod 2^SWITCH_WIDTH (natural wrap).
- Static mode: s_out = 0. The LFSR and ptr hold.
- The LFSR and ptr advance only on an input handshake (in_valid && in_ready), never on stalls.
- Output register:
  - Loads on an input handshake.
  - Clears out_valid when out_ready is high and no new sample is loaded.
  - Holds all outputs stable while out_valid && !out_ready.

## Timing
- Reset values:
  - Registers: state=IDLE, out_valid=0, out_level=0, s_out=0, out_sat=0, lfsr=DEFAULT_SEED, ptr=0, mode=static.
  - Combinational outputs: cfg_ready=1, in_ready=0.
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N; one sample per cycle at full throughput.
- Simultaneous out pop and in push in RUN: the register reloads and out_valid stays 1.
- cfg_valid and in_valid in the same RUN cycle: config wins and the sample is not taken.
- cfg_ready is combinational from state only; in_ready is combinational from state, cfg_valid, out_valid and out_ready.
- Reset mid-operation (any state): the pending output is dropped and all registers return to their reset values on that edge.
- Mode change via LOAD: the new schedule applies to the first sample accepted after LOAD.

## Test plan
- Reset, then config mode=PN with seed=0xACE1; send x_in=50 twice.
  - Expect level=19 on both samples.
  - Expect s_out=0x01, then 0x03 (LFSR 0xACE1 -> 0x59C3), out_sat=0.
- Config mode=rotate; send x_in=50, 50, 0.
  - Expect levels 19, 19, 16.
  - Expect s_out 0, 19, 6 (ptr wraps 38 mod 32).
- Boundaries:
  - x_in=1000 -> level=31, out_sat=1.
  - x_in=-50 -> level=12, out_sat=0.
  - x_in=-32768 -> level=0, out_sat=1.
  - x_in=0 -> level=16.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1.
  - Expect one output held stable and in_ready=0.
  - Expect the LFSR not to advance; then full throughput, one result per cycle.
- Reconfig: cfg_valid with seed=0 raised mid-stream while an output is pending.
  - Expect DRAIN until the pop, then LOAD with cfg_ready=1.
  - Expect the LFSR to reload 0xACE1; the next sample gives s_out=0x01.
- Reset asserted in RUN with out_valid=1: next cycle out_valid=0, state IDLE, cfg_ready=1, in_ready=0.
